// File: rtl/data_mem_be_if.sv
// Request/response and debug-port bundle for the byte-enabled data memory.
// The master drives requests; the slave (the memory) returns load data and status.
interface data_mem_be_if #(
  parameter int unsigned MEM_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req;
  logic                  wea;
  logic [MEM_WIDTH+1:0]  addra;
  logic [1:0]            size;
  logic                  sign_ext;
  logic [DATA_WIDTH-1:0] dina;
  logic [DATA_WIDTH-1:0] douta;
  logic                  rvalid;
  logic                  busy;
  logic                  misalign;
  logic [MEM_WIDTH-1:0]  dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_data;

  modport master (
    output req, wea, addra, size, sign_ext, dina, dbg_addr,
    input  douta, rvalid, busy, misalign, dbg_data
  );

  modport slave (
    input  req, wea, addra, size, sign_ext, dina, dbg_addr,
    output douta, rvalid, busy, misalign, dbg_data
  );
endinterface

// File: rtl/data_mem_be.sv
// Byte/half/word addressable data memory with a power-up clear sweep, misalignment
// rejection, registered loads and a combinational debug read port.
module data_mem_be #(
  parameter int unsigned MEM_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic         clka,
  input  logic         reset,
  input  logic         clkEnable,
  data_mem_be_if.slave bus
);
  localparam int unsigned Depth = 2 ** MEM_WIDTH;
  localparam logic [MEM_WIDTH-1:0] LastIdx = MEM_WIDTH'(Depth - 1);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e                state_q;
  logic [MEM_WIDTH-1:0]  clr_ptr_q;
  logic [DATA_WIDTH-1:0] douta_q;
  logic                  rvalid_q;
  logic                  misalign_q;
  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic [MEM_WIDTH-1:0]  word_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] wr_word;
  logic                  misaligned;
  logic                  clearing;
  logic                  mem_we;
  logic [MEM_WIDTH-1:0]  mem_idx;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign word_idx   = bus.addra[MEM_WIDTH+1:2];
  assign clearing   = (state_q == StClear);
  assign misaligned = ((bus.size == 2'b01) && bus.addra[0]) ||
                      (bus.size[1] && (bus.addra[1:0] != 2'b00));

  always_comb begin
    rd_word = mem_q[word_idx];
    lane_b  = rd_word[{bus.addra[1:0], 3'b000} +: 8];
    lane_h  = rd_word[{bus.addra[1], 4'b0000} +: 16];
    unique case (bus.size)
      2'b00:   load_val = {{24{bus.sign_ext & lane_b[7]}}, lane_b};
      2'b01:   load_val = {{16{bus.sign_ext & lane_h[15]}}, lane_h};
      default: load_val = rd_word;
    endcase
  end

  // Read-modify-write merge keeps the untouched lanes of the addressed word.
  always_comb begin
    wr_word = rd_word;
    unique case (bus.size)
      2'b00:   wr_word[{bus.addra[1:0], 3'b000} +: 8] = bus.dina[7:0];
      2'b01:   wr_word[{bus.addra[1], 4'b0000} +: 16] = bus.dina[15:0];
      default: wr_word = bus.dina;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = word_idx;
    mem_wdata = wr_word;
    if (clkEnable && reset) begin
      if (clearing) begin
        mem_we    = 1'b1;
        mem_idx   = clr_ptr_q;
        mem_wdata = '0;
      end else if (bus.req && bus.wea && !misaligned) begin
        mem_we = 1'b1;
      end
    end
  end

  // The array has no reset; it is zeroed only by the sweep.
  always_ff @(posedge clka) begin
    if (mem_we) begin
      mem_q[mem_idx] <= mem_wdata;
    end
  end

  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      state_q    <= StClear;
      clr_ptr_q  <= '0;
      douta_q    <= '0;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else if (clkEnable) begin
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
      unique case (state_q)
        StClear: begin
          if (clr_ptr_q == LastIdx) begin
            state_q   <= StRun;
            clr_ptr_q <= '0;
          end else begin
            clr_ptr_q <= clr_ptr_q + MEM_WIDTH'(1);
          end
        end
        StRun: begin
          if (bus.req) begin
            if (misaligned) begin
              misalign_q <= 1'b1;
            end else if (!bus.wea) begin
              douta_q  <= load_val;
              rvalid_q <= 1'b1;
            end
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

  assign bus.douta    = douta_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.misalign = misalign_q;
  assign bus.busy     = clearing;
  assign bus.dbg_data = mem_q[bus.dbg_addr];
endmodule

// File: tb/tb_data_mem_be.sv
// Self-checking bench for data_mem_be: directed scenarios plus randomized traffic
// checked against a little-endian byte-array reference model.
module tb_data_mem_be;
  localparam int unsigned MemWidth = 4;

  logic clka;
  logic reset;
  logic clkEnable;
  int   total;
  int   bad;

  data_mem_be_if #(.MEM_WIDTH(MemWidth), .DATA_WIDTH(32)) bus_if ();

  data_mem_be #(.MEM_WIDTH(MemWidth), .DATA_WIDTH(32)) dut (
    .clka      (clka),
    .reset     (reset),
    .clkEnable (clkEnable),
    .bus       (bus_if)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  logic [7:0]  ref_mem [64];
  logic [31:0] ref_douta;
  logic        ref_rvalid;
  logic        ref_mis;

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    ref_douta  = 32'h0;
    ref_rvalid = 1'b0;
    ref_mis    = 1'b0;
  endfunction

  function automatic logic [31:0] model_word(input int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  function automatic void model_access(input logic w, input logic [5:0] a, input logic [1:0] sz,
                                       input logic sx, input logic [31:0] d);
    int          nbytes;
    int          base;
    logic [31:0] v;
    nbytes     = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    base       = int'(a);
    ref_rvalid = 1'b0;
    ref_mis    = 1'b0;
    if ((base % nbytes) != 0) begin
      ref_mis = 1'b1;
      return;
    end
    if (w) begin
      for (int i = 0; i < nbytes; i++) ref_mem[base+i] = d[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nbytes; i++) v = v | (32'(ref_mem[base+i]) << (8*i));
      if (sx && nbytes < 4 && v[8*nbytes-1]) v = v | ~((32'd1 << (8*nbytes)) - 32'd1);
      ref_douta  = v;
      ref_rvalid = 1'b1;
    end
  endfunction

  // Drives one request for a single enabled edge, starting and ending on a negedge.
  task automatic issue(input logic w, input logic [5:0] a, input logic [1:0] sz,
                       input logic sx, input logic [31:0] d);
    bus_if.req      = 1'b1;
    bus_if.wea      = w;
    bus_if.addra    = a;
    bus_if.size     = sz;
    bus_if.sign_ext = sx;
    bus_if.dina     = d;
    model_access(w, a, sz, sx, d);
    @(negedge clka);
    bus_if.req = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0;
    #1;
    total++;
    if (bus_if.douta !== 32'h0 || bus_if.rvalid !== 1'b0 || bus_if.misalign !== 1'b0 ||
        bus_if.busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_state douta=%h rvalid=%b misalign=%b busy=%b want 0/0/0/1",
               bus_if.douta, bus_if.rvalid, bus_if.misalign, bus_if.busy);
    end
    @(negedge clka);
    reset = 1'b1;
    n = 0;
    do begin
      @(posedge clka);
      #1;
      n++;
    end while (bus_if.busy && n < 100);
    total++;
    if (n != 16 || bus_if.busy !== 1'b0) begin
      bad++;
      $display("FAIL sweep_len edges=%0d busy=%b want 16/0", n, bus_if.busy);
    end
    @(negedge clka);
    model_clear();
    for (int i = 0; i < 16; i++) begin
      bus_if.dbg_addr = MemWidth'(i);
      #1;
      total++;
      if (bus_if.dbg_data !== 32'h0) begin
        bad++;
        $display("FAIL sweep_zero word=%0d got=%h want=0", i, bus_if.dbg_data);
      end
    end
    @(negedge clka);
  endtask

  task automatic test_directed();
    issue(1'b1, 6'h08, 2'b10, 1'b0, 32'hA1B2C3D4);
    total++;
    if (bus_if.rvalid !== 1'b0 || bus_if.douta !== 32'h0) begin
      bad++;
      $display("FAIL store_no_rvalid rvalid=%b douta=%h want 0/0", bus_if.rvalid, bus_if.douta);
    end
    issue(1'b1, 6'h09, 2'b00, 1'b0, 32'h000000EE);
    bus_if.dbg_addr = 4'd2;
    #1;
    total++;
    if (bus_if.dbg_data !== 32'hA1B2EED4) begin
      bad++;
      $display("FAIL byte_merge got=%h want=a1b2eed4", bus_if.dbg_data);
    end
    @(negedge clka);
    issue(1'b0, 6'h09, 2'b00, 1'b1, 32'h0);
    total++;
    if (bus_if.douta !== 32'hFFFFFFEE || bus_if.rvalid !== 1'b1) begin
      bad++;
      $display("FAIL load_byte_sx douta=%h rvalid=%b want ffffffee/1", bus_if.douta, bus_if.rvalid);
    end
    @(negedge clka);
    total++;
    if (bus_if.rvalid !== 1'b0 || bus_if.douta !== 32'hFFFFFFEE) begin
      bad++;
      $display("FAIL rvalid_pulse rvalid=%b douta=%h want 0/ffffffee", bus_if.rvalid, bus_if.douta);
    end
    issue(1'b0, 6'h0A, 2'b01, 1'b0, 32'h0);
    total++;
    if (bus_if.douta !== 32'h0000A1B2 || bus_if.rvalid !== 1'b1) begin
      bad++;
      $display("FAIL load_half_zx douta=%h rvalid=%b want 0000a1b2/1", bus_if.douta, bus_if.rvalid);
    end
    issue(1'b0, 6'h0A, 2'b01, 1'b1, 32'h0);
    total++;
    if (bus_if.douta !== 32'hFFFFA1B2) begin
      bad++;
      $display("FAIL load_half_sx douta=%h want ffffa1b2", bus_if.douta);
    end
    @(negedge clka);
    issue(1'b1, 6'h06, 2'b10, 1'b0, 32'hDEADBEEF);
    total++;
    if (bus_if.misalign !== 1'b1 || bus_if.rvalid !== 1'b0 || bus_if.douta !== 32'hFFFFA1B2) begin
      bad++;
      $display("FAIL mis_word misalign=%b rvalid=%b douta=%h want 1/0/ffffa1b2",
               bus_if.misalign, bus_if.rvalid, bus_if.douta);
    end
    issue(1'b0, 6'h03, 2'b01, 1'b0, 32'h0);
    total++;
    if (bus_if.misalign !== 1'b1 || bus_if.rvalid !== 1'b0 || bus_if.douta !== 32'hFFFFA1B2) begin
      bad++;
      $display("FAIL mis_half misalign=%b rvalid=%b douta=%h want 1/0/ffffa1b2",
               bus_if.misalign, bus_if.rvalid, bus_if.douta);
    end
    @(negedge clka);
    total++;
    if (bus_if.misalign !== 1'b0) begin
      bad++;
      $display("FAIL mis_pulse misalign=%b want 0", bus_if.misalign);
    end
    bus_if.dbg_addr = 4'd1;
    #1;
    total++;
    if (bus_if.dbg_data !== 32'h0) begin
      bad++;
      $display("FAIL mis_no_write word1=%h want 0", bus_if.dbg_data);
    end
    @(negedge clka);
  endtask

  task automatic test_random();
    logic        en;
    logic        rq;
    logic [31:0] exp_douta;
    logic        exp_rv;
    logic        exp_mis;
    int          w;
    for (int k = 0; k < 300; k++) begin
      en = ($urandom_range(0, 4) != 0);
      rq = ($urandom_range(0, 3) != 0);
      bus_if.req      = rq;
      bus_if.wea      = 1'($urandom_range(0, 1));
      bus_if.addra    = 6'($urandom_range(0, 63));
      bus_if.size     = 2'($urandom_range(0, 3));
      bus_if.sign_ext = 1'($urandom_range(0, 1));
      bus_if.dina     = $urandom;
      clkEnable       = en;
      if (en) begin
        if (rq) begin
          model_access(bus_if.wea, bus_if.addra, bus_if.size, bus_if.sign_ext, bus_if.dina);
        end else begin
          ref_rvalid = 1'b0;
          ref_mis    = 1'b0;
        end
      end
      exp_douta = ref_douta;
      exp_rv    = ref_rvalid;
      exp_mis   = ref_mis;
      @(negedge clka);
      bus_if.req = 1'b0;
      clkEnable  = 1'b1;
      total++;
      if (bus_if.douta !== exp_douta || bus_if.rvalid !== exp_rv || bus_if.misalign !== exp_mis)
      begin
        bad++;
        $display("FAIL rand_op k=%0d douta=%h rvalid=%b misalign=%b want %h/%b/%b",
                 k, bus_if.douta, bus_if.rvalid, bus_if.misalign, exp_douta, exp_rv, exp_mis);
      end
      w = int'($urandom_range(0, 15));
      bus_if.dbg_addr = MemWidth'(w);
      #1;
      total++;
      if (bus_if.dbg_data !== model_word(w)) begin
        bad++;
        $display("FAIL rand_dbg k=%0d word=%0d got=%h want=%h", k, w, bus_if.dbg_data,
                 model_word(w));
      end
    end
    @(negedge clka);
  endtask

  task automatic test_sweep_gating();
    int n;
    int evts;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    bus_if.req      = 1'b1;
    bus_if.wea      = 1'b1;
    bus_if.addra    = 6'h00;
    bus_if.size     = 2'b10;
    bus_if.dina     = 32'h5A5A5A5A;
    n    = 0;
    evts = 0;
    do begin
      @(posedge clka);
      #1;
      n++;
      if (bus_if.rvalid !== 1'b0 || bus_if.misalign !== 1'b0) evts++;
      if (n == 5) clkEnable = 1'b0;
      if (n == 10) clkEnable = 1'b1;
    end while (bus_if.busy && n < 100);
    bus_if.req = 1'b0;
    total++;
    if (n != 21) begin
      bad++;
      $display("FAIL sweep_gated edges=%0d want 21", n);
    end
    total++;
    if (evts != 0) begin
      bad++;
      $display("FAIL sweep_quiet pulses=%0d want 0", evts);
    end
    model_clear();
    @(negedge clka);
    bus_if.dbg_addr = 4'd0;
    #1;
    total++;
    if (bus_if.dbg_data !== 32'h0) begin
      bad++;
      $display("FAIL sweep_store_ignored word0=%h want 0", bus_if.dbg_data);
    end
    @(negedge clka);
  endtask

  task automatic test_reset_mid();
    int n;
    int rv_seen;
    issue(1'b1, 6'h00, 2'b10, 1'b0, 32'h12345678);
    issue(1'b0, 6'h00, 2'b10, 1'b0, 32'h0);
    total++;
    if (bus_if.douta !== 32'h12345678) begin
      bad++;
      $display("FAIL pre_reset_load douta=%h want 12345678", bus_if.douta);
    end
    bus_if.req   = 1'b1;
    bus_if.wea   = 1'b0;
    bus_if.addra = 6'h00;
    bus_if.size  = 2'b10;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (bus_if.douta !== 32'h0 || bus_if.busy !== 1'b1 || bus_if.rvalid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset douta=%h busy=%b rvalid=%b want 0/1/0",
               bus_if.douta, bus_if.busy, bus_if.rvalid);
    end
    reset = 1'b1;
    n       = 0;
    rv_seen = 0;
    do begin
      @(posedge clka);
      #1;
      n++;
      if (bus_if.rvalid !== 1'b0) rv_seen++;
    end while (bus_if.busy && n < 100);
    bus_if.req = 1'b0;
    total++;
    if (n != 16 || rv_seen != 0) begin
      bad++;
      $display("FAIL resweep edges=%0d rvalid_seen=%0d want 16/0", n, rv_seen);
    end
    @(negedge clka);
    total++;
    if (bus_if.rvalid !== 1'b0 || bus_if.douta !== 32'h0) begin
      bad++;
      $display("FAIL post_sweep rvalid=%b douta=%h want 0/0", bus_if.rvalid, bus_if.douta);
    end
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    clkEnable       = 1'b1;
    bus_if.req      = 1'b0;
    bus_if.wea      = 1'b0;
    bus_if.addra    = '0;
    bus_if.size     = 2'b00;
    bus_if.sign_ext = 1'b0;
    bus_if.dina     = '0;
    bus_if.dbg_addr = '0;
    model_clear();
    test_reset();
    test_directed();
    test_random();
    test_sweep_gating();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/data_mem_be.md
DATA_MEM_BE -- requirements
Module: data_mem_be

Interface
REQ-001 SHALL have parameter MEM_WIDTH, default 4, meaning log2 of the word depth (2**MEM_WIDTH words of 32 bits).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning word width; only 32 is supported.
REQ-003 SHALL have port clka  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port clkEnable  input  1  when 0, every register, FSM state and the array hold their values.
REQ-006 SHALL have port req  input  1  access request, sampled on an enabled edge.
REQ-007 SHALL have port wea  input  1  1 = store, 0 = load; qualified by req.
REQ-008 SHALL have port addra  input  MEM_WIDTH+2  byte address; [1:0] select the byte, [MEM_WIDTH+1:2] select the word.
REQ-009 SHALL have port size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-010 SHALL have port sign_ext  input  1  1 = sign-extend byte/half loads, 0 = zero-extend.
REQ-011 SHALL have port dina  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port douta  output  32  registered load result.
REQ-013 SHALL have port rvalid  output  1  one-cycle pulse marking new douta.
REQ-014 SHALL have port busy  output  1  1 while the clear sweep runs; requests are ignored.
REQ-015 SHALL have port misalign  output  1  one-cycle pulse flagging a rejected misaligned access.
REQ-016 SHALL have port dbg_addr  input  MEM_WIDTH  word index for the debug read port.
REQ-017 SHALL have port dbg_data  output  32  combinational contents of word dbg_addr.

Function
REQ-018 SHALL implement a two-state FSM, CLEAR and RUN; reset forces CLEAR with clear pointer 0.
REQ-019 In CLEAR, each enabled edge SHALL write 0 to word clr_ptr and increment it; the edge that clears word 2**MEM_WIDTH-1 SHALL move to RUN and reset clr_ptr to 0.
REQ-020 busy SHALL be 1 exactly while in CLEAR; the sweep SHALL take 2**MEM_WIDTH enabled cycles.
REQ-021 In CLEAR, req SHALL be ignored: no write, and rvalid and misalign stay 0.
REQ-022 In RUN, an access SHALL be accepted on an enabled edge with req=1.
REQ-023 An access SHALL be misaligned when it is a half with addra[0]=1, or a word with addra[1:0]!=0.
REQ-024 A misaligned access SHALL neither write nor load; misalign=1 for the next cycle only, rvalid=0 and douta unchanged.
REQ-025 An aligned store SHALL use little-endian lanes and leave all other bytes unchanged:
  - byte: dina[7:0] to bits [8k+7:8k], k=addra[1:0]
  - half: dina[15:0] to bits [16h+15:16h], h=addra[1]
  - word: all 32 bits.
REQ-026 An aligned load SHALL register the selected lane into douta, right-aligned and extended per sign_ext (word unaffected), with rvalid=1 for exactly one cycle; latency is one enabled edge.
REQ-027 A store SHALL NOT assert rvalid and SHALL NOT change douta.
REQ-028 Without an accepted load or misaligned access on an enabled edge, rvalid and misalign SHALL return to 0; douta SHALL hold its value.
REQ-029 dbg_data SHALL reflect the array combinationally: it shows old data until the write edge, and new data after it.
REQ-030 Address bits above the array depth do not exist; addra covers exactly 2**MEM_WIDTH words, with no wrap or alias logic.

Reset
REQ-031 Asserting reset (low) SHALL immediately set douta=0, rvalid=0, misalign=0, busy=1, state=CLEAR and clr_ptr=0, independent of clka and clkEnable.
REQ-032 Reset asserted mid-sweep or mid-access SHALL abort the sweep or access, and the sweep SHALL restart from word 0 after release.
REQ-033 The array SHALL NOT be asynchronously reset; zeroing occurs only through the sweep.

Verification
REQ-034 Release reset with clkEnable=1, MEM_WIDTH=4 -> busy=1 for exactly 16 edges, then 0; dbg_data=0 for all dbg_addr 0..15.
REQ-035 Store word 0xA1B2C3D4 at 0x08, then byte 0xEE at 0x09 -> dbg_addr=2 shows 0xA1B2EED4; a load of byte 0x09 with sign_ext=1 -> next cycle douta=0xFFFFFFEE, rvalid=1 for one cycle.
REQ-036 Load half at 0x0A with sign_ext=0 after REQ-035 -> douta=0x0000A1B2; the same load with sign_ext=1 -> 0xFFFFA1B2.
REQ-037 Word store at 0x06 and half load at 0x03 -> misalign=1 for one cycle each, array unchanged, rvalid=0, douta unchanged.
REQ-038 During the sweep issue a store with req=1; then drop clkEnable for 5 cycles mid-sweep -> the store has no effect; busy is extended by exactly 5 cycles.
REQ-039 Pull reset low for 1 ns between edges in RUN, with a load pending -> douta=0 and busy=1 immediately; after release, a full 16-cycle sweep runs and no rvalid occurs.
